dm_arbiter: RTL

- Shares the single-port data memory (4096 x 32-bit words, word index addr[13:2], combinational read, write on posedge clk) between two requesters: port 0 = CPU MEM stage, port 1 = DMA/debug loader.
- Round-robin arbitration with a 3-state access sequencer.
- Registered memory-side signals and a registered acknowledge.
- Out-of-range accesses are blocked and flagged.

---
 rtl/dm_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU MEM stage (port 0) and the DMA/debug loader (port 1).
// Optional write logging is compiled in when DM_ARBITER_LOG_EN is defined; the default build is silent.
module dm_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
    parameter int          FIRST_PORT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wd0,
    input  logic [31:0] pc0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wd1,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // With last_grant pointing at the other port, FIRST_PORT wins the first contended round.
    localparam logic LAST_GRANT_RST = (FIRST_PORT == 0) ? 1'b1 : 1'b0;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        win_q, win_d;
    logic        we_q, we_d;
    logic        oor_q, oor_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic [31:0] mem_pc_q, mem_pc_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        pick_s;

    function automatic logic in_range(input logic [31:0] a);
        return (a < ADDR_LIMIT);
    endfunction

    // Next-state, latch and response computation for the IDLE -> ISSUE -> RESP sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        we_d         = we_q;
        oor_d        = oor_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        mem_pc_d     = mem_pc_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        pick_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        pick_s = ~last_grant_q;
                    end else begin
                        pick_s = req1;
                    end
                    win_d        = pick_s;
                    last_grant_d = pick_s;
                    if (pick_s) begin
                        we_d       = we1;
                        mem_addr_d = addr1;
                        mem_wd_d   = wd1;
                        mem_pc_d   = 32'h0000_0000;
                        oor_d      = ~in_range(addr1);
                        mem_we_d   = we1 & in_range(addr1);
                    end else begin
                        we_d       = we0;
                        mem_addr_d = addr0;
                        mem_wd_d   = wd0;
                        mem_pc_d   = pc0;
                        oor_d      = ~in_range(addr0);
                        mem_we_d   = we0 & in_range(addr0);
                    end
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!we_q && !oor_q) begin
                    rdata_d = mem_rd;
                end else begin
                    rdata_d = 32'h0000_0000;
                end
                err_d   = oor_q;
                ack0_d  = ~win_q;
                ack1_d  = win_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any latched access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_GRANT_RST;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wd_q     <= 32'h0000_0000;
            mem_pc_q     <= 32'h0000_0000;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            mem_pc_q     <= mem_pc_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // A write whose ISSUE cycle meets a reset edge must not reach memory.
    assign mem_we   = mem_we_q & ~reset;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign mem_pc   = mem_pc_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata    = rdata_q;
    assign err      = err_q;

`ifdef DM_ARBITER_LOG_EN
    // Team-standard write log, emitted at the edge that ends ISSUE.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_ISSUE) && we_q) begin
            if (!oor_q) begin
                $display("%d@%h: *%h <= %h", $time, mem_pc, mem_addr, mem_wd);
            end else begin
                $display("%d@%h: DM range error *%h", $time, mem_pc, mem_addr);
            end
        end
    end
`else
`endif

endmodule
